// File: rtl/sw_broadcast_ctrl.sv
// sw_broadcast_ctrl: in-order store broadcast queue with drain-before-switch serial/parallel mode control
module sw_broadcast_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_ready,
    input  logic          par_req,
    input  logic          child_sw_empty,
    output logic          parallel,
    output logic          bc_valid,
    output logic [AW-1:0] bc_addr,
    output logic [31:0]   bc_data,
    input  logic          bc_ready,
    output logic          busy
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {SERIAL, DRAIN, PARALLEL, RESYNC} state_t;
    state_t         state_q, state_d;
    logic [1:0]     rst_sync_q;
    logic           rst_ni;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           parallel_q, parallel_d;
    logic [AW+31:0] mem_q [DEPTH];
    logic           enq, deq;

    // reset asserts at once but releases only after two clean clock edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ni = rst_sync_q[1];

    // stores are only taken in serial mode; a full queue still accepts when its head leaves this cycle
    assign st_ready = rst_ni && state_q == SERIAL && (count_q < (PW+1)'(DEPTH) || bc_ready);
    assign enq      = st_valid && st_ready;
    assign bc_valid = count_q != '0;
    assign deq      = bc_valid && bc_ready;
    assign {bc_addr, bc_data} = mem_q[rd_ptr_q];
    assign parallel = parallel_q;
    assign busy     = bc_valid || state_q == DRAIN || state_q == RESYNC;

    // pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + (PW+1)'(enq) - (PW+1)'(deq);
    end

    // mode sequencing: serial -> drain until empty -> parallel -> wait for children -> serial
    always_comb begin
        state_d = state_q;
        case (state_q)
            SERIAL:   if (par_req) state_d = DRAIN;
            DRAIN:    state_d = !par_req ? SERIAL : (count_d == '0 ? PARALLEL : DRAIN);
            PARALLEL: if (!par_req) state_d = RESYNC;
            RESYNC:   if (child_sw_empty) state_d = SERIAL;
            default:  state_d = SERIAL;
        endcase
        parallel_d = state_d == PARALLEL || state_d == RESYNC;
    end

    // queue storage needs no reset; only entries below count are ever observed
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= {st_addr, st_data};
    end

    // control state registers
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= SERIAL;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            parallel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            parallel_q <= parallel_d;
        end
    end
endmodule

// File: tb/tb_sw_broadcast_ctrl.sv
// tb_sw_broadcast_ctrl: vector table, corner sequences and randomized traffic against a queue-based model
module tb_sw_broadcast_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int M_SERIAL = 0, M_DRAIN = 1, M_PAR = 2, M_RESYNC = 3;

    logic          clk = 1'b0, reset_n = 1'b1;
    logic          st_valid = 1'b0, par_req = 1'b0, child_sw_empty = 1'b1, bc_ready = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [31:0]   st_data = '0;
    logic          st_ready, parallel, bc_valid, busy;
    logic [AW-1:0] bc_addr;
    logic [31:0]   bc_data;

    always #5 clk = ~clk;

    sw_broadcast_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .par_req(par_req), .child_sw_empty(child_sw_empty), .parallel(parallel),
        .bc_valid(bc_valid), .bc_addr(bc_addr), .bc_data(bc_data), .bc_ready(bc_ready), .busy(busy)
    );

    int tests = 0, fails = 0;
    logic [AW+31:0] mq[$];
    int   mode = M_SERIAL;
    logic mpar = 1'b0;
    logic s_bcv, s_sr, s_par, s_busy;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_data;

    typedef struct {
        logic sv; logic [AW-1:0] a; logic [31:0] d; logic bcr;
        logic bcv; logic [AW-1:0] ea; logic [31:0] ed; logic sr; logic bsy;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t v(logic sv, logic [AW-1:0] a, logic [31:0] d, logic bcr,
                               logic bcv, logic [AW-1:0] ea, logic [31:0] ed, logic sr, logic bsy);
        vec_t r;
        r.sv = sv; r.a = a; r.d = d; r.bcr = bcr;
        r.bcv = bcv; r.ea = ea; r.ed = ed; r.sr = sr; r.bsy = bsy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock cycle: entered and left at posedge+1; stores are offered only when the model says ready
    task automatic step(input logic want, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic bcr, input logic pr, input logic cse);
        logic e_bcv, e_sr, e_par, e_busy, en, de;
        logic [AW+31:0] head;
        e_bcv  = mq.size() != 0;
        e_sr   = mode == M_SERIAL && (mq.size() < DEPTH || bcr);
        e_par  = mpar;
        e_busy = e_bcv || mode == M_DRAIN || mode == M_RESYNC;
        head   = e_bcv ? mq[0] : '0;
        bc_ready = bcr; par_req = pr; child_sw_empty = cse;
        st_addr = a; st_data = d;
        st_valid = want && e_sr;
        #1;
        if (st_valid) chk("protocol", {63'd0, st_valid && !st_ready}, 64'd0);
        @(negedge clk);
        s_bcv = bc_valid; s_sr = st_ready; s_par = parallel; s_busy = busy;
        s_addr = bc_addr; s_data = bc_data;
        chk("bc_valid", {63'd0, bc_valid}, {63'd0, e_bcv});
        chk("st_ready", {63'd0, st_ready}, {63'd0, e_sr});
        chk("parallel", {63'd0, parallel}, {63'd0, e_par});
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        if (e_bcv) chk("bc_head", {16'd0, bc_addr, bc_data}, {16'd0, head});
        @(posedge clk);
        en = st_valid && e_sr;
        de = e_bcv && bcr;
        if (de) void'(mq.pop_front());
        if (en) mq.push_back({a, d});
        case (mode)
            M_SERIAL: if (pr) mode = M_DRAIN;
            M_DRAIN:  if (!pr) mode = M_SERIAL; else if (mq.size() == 0) mode = M_PAR;
            M_PAR:    if (!pr) mode = M_RESYNC;
            default:  if (cse) mode = M_SERIAL;
        endcase
        mpar = mode == M_PAR || mode == M_RESYNC;
        #1;
        st_valid = 1'b0;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        st_valid = 1'b0; par_req = 1'b0; bc_ready = 1'b0; child_sw_empty = 1'b1;
        #1;
        chk("rst_bc_valid", {63'd0, bc_valid}, 64'd0);
        chk("rst_parallel", {63'd0, parallel}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_st_ready", {63'd0, st_ready}, 64'd0);
        mq.delete();
        mode = M_SERIAL;
        mpar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic pr;
        logic [AW-1:0] na;
        tbl[0]  = v(1, 16'h12, 32'hDEADBEEF, 1, 0, 16'h0,  32'h0,        1, 0);
        tbl[1]  = v(0, 16'h0,  32'h0,        1, 1, 16'h12, 32'hDEADBEEF, 1, 1);
        tbl[2]  = v(0, 16'h0,  32'h0,        1, 0, 16'h0,  32'h0,        1, 0);
        tbl[3]  = v(1, 16'h1,  32'h101,      0, 0, 16'h0,  32'h0,        1, 0);
        tbl[4]  = v(1, 16'h2,  32'h102,      0, 1, 16'h1,  32'h101,      1, 1);
        tbl[5]  = v(1, 16'h3,  32'h103,      0, 1, 16'h1,  32'h101,      1, 1);
        tbl[6]  = v(1, 16'h4,  32'h104,      0, 1, 16'h1,  32'h101,      1, 1);
        tbl[7]  = v(0, 16'h0,  32'h0,        0, 1, 16'h1,  32'h101,      0, 1);
        tbl[8]  = v(1, 16'h5,  32'h105,      1, 1, 16'h1,  32'h101,      1, 1);
        tbl[9]  = v(0, 16'h0,  32'h0,        1, 1, 16'h2,  32'h102,      1, 1);
        tbl[10] = v(0, 16'h0,  32'h0,        1, 1, 16'h3,  32'h103,      1, 1);
        tbl[11] = v(0, 16'h0,  32'h0,        1, 1, 16'h4,  32'h104,      1, 1);
        tbl[12] = v(0, 16'h0,  32'h0,        1, 1, 16'h5,  32'h105,      1, 1);
        tbl[13] = v(0, 16'h0,  32'h0,        1, 0, 16'h0,  32'h0,        1, 0);

        do_reset();

        // single store latency, then full queue with a same-cycle dequeue still accepting
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].sv, tbl[i].a, tbl[i].d, tbl[i].bcr, 1'b0, 1'b1);
            chk("tbl_bc_valid", {63'd0, s_bcv}, {63'd0, tbl[i].bcv});
            chk("tbl_st_ready", {63'd0, s_sr}, {63'd0, tbl[i].sr});
            chk("tbl_busy", {63'd0, s_busy}, {63'd0, tbl[i].bsy});
            chk("tbl_parallel", {63'd0, s_par}, 64'd0);
            if (tbl[i].bcv) chk("tbl_head", {16'd0, s_addr, s_data}, {16'd0, tbl[i].ea, tbl[i].ed});
        end

        // drain of three entries before entering parallel mode
        for (int i = 0; i < 3; i++) step(1'b1, AW'(16'h31 + i), 32'h300 + i, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("drain_enter_sr", {63'd0, s_sr}, 64'd1);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("drain_sr0", {63'd0, s_sr}, 64'd0);
        chk("drain_par0", {63'd0, s_par}, 64'd0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("drain_par1", {63'd0, s_par}, 64'd0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("par_rise", {63'd0, s_par}, 64'd1);
        chk("par_sr", {63'd0, s_sr}, 64'd0);
        chk("par_idle", {63'd0, s_busy}, 64'd0);

        // leaving parallel waits for the children to empty
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            chk("resync_par", {63'd0, s_par}, 64'd1);
            chk("resync_sr", {63'd0, s_sr}, 64'd0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("resync_exit_par", {63'd0, s_par}, 64'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("serial_par", {63'd0, s_par}, 64'd0);
        chk("serial_sr", {63'd0, s_sr}, 64'd1);

        // wrap-around with bc_ready toggling 1010...
        for (int i = 0; i < 20; i++) step(i < 10, AW'(16'h50 + i), 32'h5000 + i, (i % 2) == 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("wrap_empty", {63'd0, s_bcv}, 64'd0);

        // asynchronous reset in the middle of a drain
        step(1'b1, 16'h61, 32'h61, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h62, 32'h62, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_busy", {63'd0, s_busy}, 64'd1);
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_bcv", {63'd0, s_bcv}, 64'd0);
        chk("post_rst_par", {63'd0, s_par}, 64'd0);
        chk("post_rst_sr", {63'd0, s_sr}, 64'd1);

        // randomized traffic with occasional mode requests
        pr = 1'b0;
        na = 16'h100;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) pr = ~pr;
            step($urandom_range(0, 2) != 0, na, $urandom, $urandom_range(0, 2) != 0, pr,
                 $urandom_range(0, 1) == 1);
            na = na + 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sw_broadcast_ctrl.md
Name: sw_broadcast_ctrl

Overview:
Parent-side scheduler for the store-broadcast path that keeps child data memories coherent with the parent's memory. It buffers stores committed by the parent's load/store unit and drains them in order onto the child broadcast bus. It also owns the serial/parallel mode switch: a mode change happens only once pending stores have drained, so no child memory misses a write.

Parameters:
DEPTH, 4, broadcast queue entries (power of two, ≥2)
AW, DATA_MEM_WIDTH, data memory address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
st_valid  in  1  parent store committing this cycle
st_addr  in  AW  committed store address
st_data  in  32  committed store data
st_ready  out  1  queue can accept; parent LSU gates its store commit with this
par_req  in  1  level: 1 requests parallel mode, 0 requests serial mode
child_sw_empty  in  1  AND of all children's sw_empty
parallel  out  1  current mode; drives the parallel input of parent and children
bc_valid  out  1  broadcast write valid (child sw_broadcast)
bc_addr  out  AW  broadcast address
bc_data  out  32  broadcast data
bc_ready  in  1  broadcast bus accepts this cycle
busy  out  1  queue non-empty or mode switch in progress

Behaviour:
- Reset (async assert, sync deassert inside the block): state SERIAL, count=0, rd_ptr=wr_ptr=0, parallel=0, bc_valid=0, busy=0. bc_addr and bc_data are don't-care.
- Queue: circular FIFO, DEPTH entries. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- enq = st_valid && st_ready && state==SERIAL. deq = bc_valid && bc_ready.
- st_ready = state==SERIAL && (count<DEPTH || bc_ready). Full with a same-cycle dequeue still accepts.
- bc_valid = count!=0. bc_addr and bc_data come from the head entry (registered storage, no bypass). Minimum latency is 1 cycle: a store accepted at cycle t appears on bc_* at t+1.
- count_next = count + enq − deq. Enqueue and dequeue in the same cycle keep count unchanged. When count==0 there is no dequeue.
- st_valid while st_ready=0 is a protocol violation by the parent. The store is dropped, and the bench asserts this never happens.
- FSM:
  - SERIAL: parallel=0. If par_req=1, go to DRAIN.
  - DRAIN: st_ready=0. When count==0 (sampled after this cycle's deq), go to PARALLEL. If par_req drops, return to SERIAL.
  - PARALLEL: parallel=1, st_ready=0, and parent stores are not broadcast (children write locally). If par_req=0, go to RESYNC.
  - RESYNC: parallel stays 1 and st_ready=0. When child_sw_empty=1, go to SERIAL. parallel falls on the same edge, so it is 0 from the next cycle.
- busy = count!=0 || state==DRAIN || state==RESYNC.
- Mode transitions take effect on the clock edge. parallel is a registered output and is glitch-free.
- Reset asserted mid-drain clears the queue. Lost broadcasts are acceptable because the whole core resets together.
- Order guarantee: broadcasts leave in exact commit order, with no duplication and no loss.

Test Plan:
1. Reset, then one store (addr 0x12, data 0xDEADBEEF) at t0, bc_ready=1 → bc_valid=1 at t0+1 with the same addr/data for exactly 1 cycle; count returns to 0; busy falls at t0+2.
2. bc_ready=0, 4 stores (addr 1..4) → st_ready=0 after the 4th; raise bc_ready and offer a 5th (addr 5) in the same cycle → accepted; broadcasts appear in order 1,2,3,4,5 with no gaps.
3. Queue holding 3 entries, par_req=1, bc_ready=1 → st_ready=0 immediately; parallel rises 1 cycle after the 3rd dequeue; no enqueue occurs during DRAIN.
4. PARALLEL, par_req=0, child_sw_empty=0 for 5 cycles → parallel stays 1 and st_ready=0; child_sw_empty=1 → parallel=0 and st_ready=1 on the next cycle.
5. Wrap-around: 10 enqueues/dequeues interleaved with bc_ready toggling 1010… → data integrity holds across pointer wrap; count never exceeds 4.
6. reset_n pulsed low asynchronously between edges with 2 entries queued during DRAIN → outputs reset immediately; after release, state SERIAL, bc_valid=0, parallel=0.
